// File: rtl/joystick_scanner_if.sv
// DRP read channel between the joystick scanner (master) and the XADC wrapper (slave).
interface joystick_scanner_if;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_drdy;
  logic [15:0] drp_do;

  modport master (
    output drp_daddr,
    output drp_den,
    input  drp_drdy,
    input  drp_do
  );

  modport slave (
    input  drp_daddr,
    input  drp_den,
    output drp_drdy,
    output drp_do
  );
endinterface

// File: rtl/joystick_scanner.sv
// Multi-axis analog joystick front end. Round-robin polls XADC auxiliary channels
// over DRP, then classifies each sample (LOW / CENTER / HIGH with hysteresis),
// debounces over consecutive samples and emits held direction levels plus
// one-cycle press pulses.
module joystick_scanner #(
  parameter int unsigned NUM_AXES  = 2,
  parameter logic [6:0]  ADDR_BASE = 7'h16,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned TH_LOW    = 1000,
  parameter int unsigned TH_HIGH   = 3000,
  parameter int unsigned HYST      = 64,
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                       clk_1MHz,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       err_clr,
  joystick_scanner_if.master         drp,
  output logic [NUM_AXES*DATA_W-1:0] axis_data,
  output logic [NUM_AXES-1:0]        dir_low,
  output logic [NUM_AXES-1:0]        dir_high,
  output logic [NUM_AXES-1:0]        press_low,
  output logic [NUM_AXES-1:0]        press_high,
  output logic                       sample_valid,
  output logic                       timeout_err
);

  localparam int unsigned IdxW  = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam int unsigned CntW  = $clog2(DEBOUNCE + 1);

  localparam logic [IdxW-1:0]   LastIdx = IdxW'(NUM_AXES - 1);
  localparam logic [WaitW-1:0]  WaitMax = WaitW'(TIMEOUT);
  localparam logic [CntW-1:0]   DebMax  = CntW'(DEBOUNCE);
  localparam logic [DATA_W-1:0] ThLow   = DATA_W'(TH_LOW);
  localparam logic [DATA_W-1:0] ThHigh  = DATA_W'(TH_HIGH);
  // Release points: a held LOW/HIGH only lets go once the sample clears these.
  localparam logic [DATA_W-1:0] LowRel  = DATA_W'(TH_LOW + HYST);
  localparam logic [DATA_W-1:0] HighRel = DATA_W'(TH_HIGH - HYST);

  // Elaboration-time sanity checks on the parameter set.
  if (NUM_AXES < 1 || NUM_AXES > 8) begin : g_bad_axes
    $error("joystick_scanner: NUM_AXES must be 1..8");
  end
  if (DEBOUNCE < 1) begin : g_bad_deb
    $error("joystick_scanner: DEBOUNCE must be >= 1");
  end
  if (TH_LOW + HYST >= TH_HIGH - HYST) begin : g_bad_hyst
    $error("joystick_scanner: hysteresis bands overlap");
  end
  if (DATA_W < 1 || DATA_W > 16) begin : g_bad_width
    $error("joystick_scanner: DATA_W must be 1..16");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StUpdate} state_e;
  typedef enum logic [1:0] {ClsCenter, ClsLow, ClsHigh} cls_e;

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [WaitW-1:0]           wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]          sample_q, sample_d;
  logic [6:0]                 daddr_q, daddr_d;
  logic                       den_q, den_d;
  logic [NUM_AXES*DATA_W-1:0] axis_data_q, axis_data_d;
  logic [NUM_AXES-1:0]        press_low_q, press_low_d;
  logic [NUM_AXES-1:0]        press_high_q, press_high_d;
  logic                       sample_valid_q, sample_valid_d;
  logic                       timeout_err_q, timeout_err_d;

  // Per-axis debounced state, pending candidate and agreement counter.
  cls_e                       cls_q [NUM_AXES];
  cls_e                       cls_d [NUM_AXES];
  cls_e                       pend_q [NUM_AXES];
  cls_e                       pend_d [NUM_AXES];
  logic [CntW-1:0]            cnt_q [NUM_AXES];
  logic [CntW-1:0]            cnt_d [NUM_AXES];

  logic [IdxW-1:0]            idx_nxt;
  cls_e                       cur_cls;
  cls_e                       cand;
  logic [CntW-1:0]            cnt_nxt;
  logic [WaitW-1:0]           wait_inc;

  // Only the top DATA_W bits of the DRP word carry the sample.
  if (DATA_W < 16) begin : g_unused_lsb
    logic unused_do_lsb;
    assign unused_do_lsb = ^drp.drp_do[15-DATA_W:0];
  end

  // Round-robin successor of the current axis index.
  always_comb begin
    idx_nxt = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
  end

  // Classify the latched sample against the current axis state.
  always_comb begin
    cur_cls = cls_q[idx_q];
    cand    = ClsCenter;
    if (sample_q < ThLow) begin
      cand = ClsLow;
    end else if (sample_q > ThHigh) begin
      cand = ClsHigh;
    end else if (cur_cls == ClsLow && sample_q < LowRel) begin
      cand = ClsLow;
    end else if (cur_cls == ClsHigh && sample_q > HighRel) begin
      cand = ClsHigh;
    end
  end

  // Next-state logic for the poll FSM, the sample path and the debouncers.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    wait_cnt_d     = wait_cnt_q;
    sample_d       = sample_q;
    daddr_d        = daddr_q;
    den_d          = 1'b0;
    axis_data_d    = axis_data_q;
    press_low_d    = '0;
    press_high_d   = '0;
    sample_valid_d = 1'b0;
    cls_d          = cls_q;
    pend_d         = pend_q;
    cnt_d          = cnt_q;
    cnt_nxt        = '0;
    wait_inc       = wait_cnt_q + WaitW'(1);
    // Clear first so that a timeout in the same cycle takes precedence.
    timeout_err_d  = timeout_err_q & ~err_clr;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StIssue;
          daddr_d = ADDR_BASE + 7'(idx_q);
          den_d   = 1'b1;
        end
      end

      StIssue: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end

      StWait: begin
        if (drp.drp_drdy) begin
          sample_d = drp.drp_do[15 -: DATA_W];
          state_d  = StUpdate;
        end else if (wait_inc == WaitMax) begin
          timeout_err_d = 1'b1;
          idx_d         = idx_nxt;
          state_d       = StIdle;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      StUpdate: begin
        axis_data_d[int'(idx_q)*DATA_W +: DATA_W] = sample_q;
        sample_valid_d = 1'b1;
        if (cand == cur_cls) begin
          cnt_d[idx_q] = '0;
        end else begin
          if (cand == pend_q[idx_q]) begin
            cnt_nxt = cnt_q[idx_q] + CntW'(1);
          end else begin
            pend_d[idx_q] = cand;
            cnt_nxt       = CntW'(1);
          end
          if (cnt_nxt == DebMax) begin
            cls_d[idx_q] = cand;
            cnt_d[idx_q] = '0;
            press_low_d[idx_q]  = (cand == ClsLow);
            press_high_d[idx_q] = (cand == ClsHigh);
          end else begin
            cnt_d[idx_q] = cnt_nxt;
          end
        end
        idx_d   = idx_nxt;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers; asynchronous reset aborts any DRP transaction.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      wait_cnt_q     <= '0;
      sample_q       <= '0;
      daddr_q        <= '0;
      den_q          <= 1'b0;
      axis_data_q    <= '0;
      press_low_q    <= '0;
      press_high_q   <= '0;
      sample_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_AXES); i++) begin
        cls_q[i]  <= ClsCenter;
        pend_q[i] <= ClsCenter;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      wait_cnt_q     <= wait_cnt_d;
      sample_q       <= sample_d;
      daddr_q        <= daddr_d;
      den_q          <= den_d;
      axis_data_q    <= axis_data_d;
      press_low_q    <= press_low_d;
      press_high_q   <= press_high_d;
      sample_valid_q <= sample_valid_d;
      timeout_err_q  <= timeout_err_d;
      cls_q          <= cls_d;
      pend_q         <= pend_d;
      cnt_q          <= cnt_d;
    end
  end

  // Direction levels decode straight from the registered axis state.
  always_comb begin
    for (int a = 0; a < int'(NUM_AXES); a++) begin
      dir_low[a]  = (cls_q[a] == ClsLow);
      dir_high[a] = (cls_q[a] == ClsHigh);
    end
  end

  assign drp.drp_daddr  = daddr_q;
  assign drp.drp_den    = den_q;
  assign axis_data      = axis_data_q;
  assign press_low      = press_low_q;
  assign press_high     = press_high_q;
  assign sample_valid   = sample_valid_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_joystick_scanner.sv
// Directed bench for joystick_scanner with the default two-axis configuration.
`timescale 1ns/1ps
module tb_joystick_scanner;

  logic        clk_1MHz = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en       = 1'b0;
  logic        err_clr  = 1'b0;
  logic [23:0] axis_data;
  logic [1:0]  dir_low, dir_high, press_low, press_high;
  logic        sample_valid, timeout_err;

  int checks = 0;
  int errors = 0;

  joystick_scanner_if bus ();

  joystick_scanner dut (
    .clk_1MHz     (clk_1MHz),
    .rst_n        (rst_n),
    .en           (en),
    .err_clr      (err_clr),
    .drp          (bus),
    .axis_data    (axis_data),
    .dir_low      (dir_low),
    .dir_high     (dir_high),
    .press_low    (press_low),
    .press_high   (press_high),
    .sample_valid (sample_valid),
    .timeout_err  (timeout_err)
  );

  always #500 clk_1MHz = ~clk_1MHz;

  // Serve one DRP read: expect den at exp_addr, answer with drdy two cycles later,
  // then report the axis outputs seen in the cycle after UPDATE.
  task automatic serve(input logic [6:0] exp_addr, input logic [11:0] smp, input int ax,
                       output logic [1:0] dl, output logic [1:0] dh,
                       output logic [1:0] pl, output logic [1:0] ph);
    int n = 0;
    dl = '0; dh = '0; pl = '0; ph = '0;
    while (bus.drp_den !== 1'b1 && n < 50) begin
      @(negedge clk_1MHz);
      n++;
    end
    checks++;
    if (bus.drp_den !== 1'b1) begin
      errors++;
      $display("FAIL serve_den got=%b want=1", bus.drp_den);
      return;
    end
    checks++;
    if (bus.drp_daddr !== exp_addr) begin
      errors++;
      $display("FAIL serve_daddr got=%h want=%h", bus.drp_daddr, exp_addr);
    end
    @(negedge clk_1MHz);
    checks++;
    if (bus.drp_den !== 1'b0) begin
      errors++;
      $display("FAIL den_width got=%b want=0", bus.drp_den);
    end
    @(negedge clk_1MHz);
    bus.drp_drdy = 1'b1;
    bus.drp_do   = {smp, 4'h0};
    @(negedge clk_1MHz);
    bus.drp_drdy = 1'b0;
    bus.drp_do   = '0;
    @(negedge clk_1MHz);
    checks++;
    if (sample_valid !== 1'b1) begin
      errors++;
      $display("FAIL sample_valid_pulse got=%b want=1", sample_valid);
    end
    checks++;
    if (axis_data[ax*12 +: 12] !== smp) begin
      errors++;
      $display("FAIL axis_data[%0d] got=%h want=%h", ax, axis_data[ax*12 +: 12], smp);
    end
    dl = dir_low; dh = dir_high; pl = press_low; ph = press_high;
    @(negedge clk_1MHz);
    checks++;
    if (sample_valid !== 1'b0 || press_low !== 2'b00 || press_high !== 2'b00) begin
      errors++;
      $display("FAIL pulse_width got=%b%b%b want=00000", sample_valid, press_low, press_high);
    end
  endtask

  // One full round: axis0 then axis1; returns axis outputs after the axis1 update.
  task automatic serve_pair(input logic [11:0] s0, input logic [11:0] s1,
                            output logic [1:0] dl, output logic [1:0] dh,
                            output logic [1:0] pl, output logic [1:0] ph);
    logic [1:0] a, b, c, d;
    serve(7'h16, s0, 0, a, b, c, d);
    serve(7'h17, s1, 1, dl, dh, pl, ph);
  endtask

  task automatic test_reset();
    bus.drp_drdy = 1'b0;
    bus.drp_do   = 16'hffff;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_1MHz);
      bus.drp_drdy = ~bus.drp_drdy;
    end
    checks++;
    if ({axis_data, dir_low, dir_high, press_low, press_high, sample_valid, timeout_err,
         bus.drp_den, bus.drp_daddr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h/%b%b%b%b%b%b/%b/%h want=0", axis_data, dir_low,
               dir_high, press_low, press_high, sample_valid, timeout_err, bus.drp_den,
               bus.drp_daddr);
    end
    bus.drp_drdy = 1'b0;
    bus.drp_do   = '0;
    en = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk_1MHz);
    checks++;
    if (bus.drp_den !== 1'b0 || bus.drp_daddr !== 7'h00) begin
      errors++;
      $display("FAIL idle_no_en got=%b/%h want=0/00", bus.drp_den, bus.drp_daddr);
    end
  endtask

  task automatic test_scan();
    logic [1:0] dl, dh, pl, ph;
    en = 1'b1;
    serve(7'h16, 12'h800, 0, dl, dh, pl, ph);
    serve(7'h17, 12'h800, 1, dl, dh, pl, ph);
    serve(7'h16, 12'h800, 0, dl, dh, pl, ph);
    checks++;
    if (axis_data !== 24'h800800 || dl !== 2'b00 || dh !== 2'b00) begin
      errors++;
      $display("FAIL scan_center got=%h/%b/%b want=800800/00/00", axis_data, dl, dh);
    end
    serve(7'h17, 12'h800, 1, dl, dh, pl, ph);
  endtask

  task automatic test_debounce();
    logic [1:0] dl, dh, pl, ph;
    for (int i = 0; i < 3; i++) begin
      serve_pair(12'h800, 12'd256, dl, dh, pl, ph);
      checks++;
      if (dl[1] !== 1'b0) begin
        errors++;
        $display("FAIL deb_early[%0d] got=%b want=0", i, dl[1]);
      end
    end
    serve_pair(12'h800, 12'd2048, dl, dh, pl, ph);
    checks++;
    if (dl[1] !== 1'b0) begin
      errors++;
      $display("FAIL deb_break got=%b want=0", dl[1]);
    end
    for (int i = 0; i < 4; i++) begin
      serve_pair(12'h800, 12'd256, dl, dh, pl, ph);
      checks++;
      if (i < 3 && (dl[1] !== 1'b0 || pl[1] !== 1'b0)) begin
        errors++;
        $display("FAIL deb_count[%0d] got=%b%b want=00", i, dl[1], pl[1]);
      end else if (i == 3 && (dl !== 2'b10 || pl !== 2'b10)) begin
        errors++;
        $display("FAIL deb_enter_low got=%b/%b want=10/10", dl, pl);
      end
    end
  endtask

  task automatic test_hysteresis();
    logic [1:0] dl, dh, pl, ph;
    for (int i = 0; i < 4; i++) begin
      serve_pair(12'h800, 12'd1050, dl, dh, pl, ph);
      checks++;
      if (dl[1] !== 1'b1 || pl[1] !== 1'b0) begin
        errors++;
        $display("FAIL hyst_hold[%0d] got=%b%b want=10", i, dl[1], pl[1]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      serve_pair(12'h800, 12'd1100, dl, dh, pl, ph);
    end
    checks++;
    if (dl !== 2'b00 || dh !== 2'b00 || pl !== 2'b00 || ph !== 2'b00) begin
      errors++;
      $display("FAIL hyst_release got=%b%b%b%b want=00000000", dl, dh, pl, ph);
    end
    for (int i = 0; i < 4; i++) begin
      serve_pair(12'h800, 12'd256, dl, dh, pl, ph);
    end
    checks++;
    if (dl !== 2'b10 || pl !== 2'b10) begin
      errors++;
      $display("FAIL relow got=%b/%b want=10/10", dl, pl);
    end
    for (int i = 0; i < 4; i++) begin
      serve_pair(12'h800, 12'd4000, dl, dh, pl, ph);
      checks++;
      if (i < 3 && dl[1] !== 1'b1) begin
        errors++;
        $display("FAIL rev_hold[%0d] got=%b want=1", i, dl[1]);
      end else if (i == 3 && (dh !== 2'b10 || dl !== 2'b00 || ph !== 2'b10 || pl !== 2'b00)) begin
        errors++;
        $display("FAIL rev_high got=%b/%b/%b/%b want=10/00/10/00", dh, dl, ph, pl);
      end
    end
  endtask

  task automatic test_timeout();
    logic [1:0] dl, dh, pl, ph;
    int n = 0;
    while (bus.drp_den !== 1'b1 && n < 50) begin
      @(negedge clk_1MHz);
      n++;
    end
    checks++;
    if (bus.drp_den !== 1'b1 || bus.drp_daddr !== 7'h16) begin
      errors++;
      $display("FAIL to_start got=%b/%h want=1/16", bus.drp_den, bus.drp_daddr);
    end
    repeat (255) @(negedge clk_1MHz);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_early got=%b want=0", timeout_err);
    end
    @(negedge clk_1MHz);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_set got=%b want=1", timeout_err);
    end
    serve(7'h17, 12'h800, 1, dl, dh, pl, ph);
    // Now in the ISSUE cycle of the next axis0 read; clear the flag here.
    checks++;
    if (bus.drp_den !== 1'b1 || bus.drp_daddr !== 7'h16) begin
      errors++;
      $display("FAIL to_next got=%b/%h want=1/16", bus.drp_den, bus.drp_daddr);
    end
    err_clr = 1'b1;
    @(negedge clk_1MHz);
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr got=%b want=0", timeout_err);
    end
    repeat (254) @(negedge clk_1MHz);
    err_clr = 1'b1;
    @(negedge clk_1MHz);
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL set_wins got=%b want=1", timeout_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    int bad = 0;
    while (bus.drp_den !== 1'b1 && n < 50) begin
      @(negedge clk_1MHz);
      n++;
    end
    @(negedge clk_1MHz);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_1MHz);
    rst_n = 1'b1;
    checks++;
    if (dir_low !== 2'b00 || dir_high !== 2'b00 || timeout_err !== 1'b0 || axis_data !== '0) begin
      errors++;
      $display("FAIL rst_mid got=%b/%b/%b/%h want=00/00/0/0", dir_low, dir_high, timeout_err,
               axis_data);
    end
    @(negedge clk_1MHz);
    checks++;
    if (bus.drp_den !== 1'b1 || bus.drp_daddr !== 7'h16) begin
      errors++;
      $display("FAIL rst_first got=%b/%h want=1/16", bus.drp_den, bus.drp_daddr);
    end
    bus.drp_drdy = 1'b1;
    bus.drp_do   = 16'h1000;
    @(negedge clk_1MHz);
    bus.drp_drdy = 1'b0;
    bus.drp_do   = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_1MHz);
      if (sample_valid !== 1'b0 || axis_data !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL late_drdy got=%0d want=0", bad);
    end
    en = 1'b0;
  endtask

  initial begin
    bus.drp_drdy = 1'b0;
    bus.drp_do   = '0;
    test_reset();
    test_scan();
    test_debounce();
    test_hysteresis();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
